pc_fetch: RTL
=============

PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 clk  input  1  Single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  Asynchronous, active-low reset.
REQ-004 sel_direccion  input  1  Jump request from execute; 1 = redirect fetch to salto this cycle.
REQ-005 salto  input  32  Jump target address, valid when sel_direccion=1.
REQ-006 salida_  output  32  Sequential next address, pc+4, combinational, feeds the address mux.
REQ-007 pc  output  32  Current fetch address register.
REQ-008 mem_req  output  1  Instruction-memory read request.
REQ-009 mem_addr  output  32  Read address; equals pc.
REQ-010 mem_ack  input  1  Memory read complete; mem_rdata valid this cycle.
REQ-011 mem_rdata  input  32  Instruction word from memory.
REQ-012 instr  output  32  Fetched instruction to decoder.
REQ-013 instr_valid  output  1  instr holds a valid, not-yet-consumed word.
REQ-014 instr_ready  input  1  Decoder accepts instr when instr_valid=1 and instr_ready=1.
REQ-015 misalign  output  1  Sticky misaligned-jump flag (see Configuration).

Function
REQ-016 States IDLE, FETCH, HOLD; mem_req=1 only in FETCH, decoded from the state register.
REQ-017 IDLE -> FETCH unconditionally on the first clock after rst_n deasserts.
REQ-018 In FETCH, mem_addr and pc shall remain stable while mem_req=1 and mem_ack=0; an issued request is never aborted.
REQ-019 sel_direccion=1 in FETCH without mem_ack: latch salto into a pending-target register, set jump_pend; pc unchanged.
REQ-020 A later sel_direccion=1 while jump_pend=1 overwrites the pending target (newest jump wins).
REQ-021 mem_ack in FETCH with jump_pend=1 or sel_direccion=1: discard mem_rdata, pc <= target (salto if sel_direccion=1, else pending target), clear jump_pend, remain in FETCH.
REQ-022 mem_ack in FETCH with no jump: instr <= mem_rdata, instr_valid <= 1, pc <= pc+4, go to HOLD.
REQ-023 In HOLD, sel_direccion=1: instr_valid <= 0 (wrong-path word dropped), pc <= salto, go to FETCH; this overrides a simultaneous instr_ready.
REQ-024 In HOLD, instr_ready=1 with no jump: instr_valid <= 0, go to FETCH next cycle.
REQ-025 In HOLD, instr and instr_valid shall hold their values until consumed or flushed.
REQ-026 sel_direccion=1 in IDLE: pc <= salto; the move to FETCH is unchanged.
REQ-027 pc+4 wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0), with no flag.
REQ-028 mem_ack outside FETCH shall be ignored.
REQ-029 Minimum throughput is one instruction per two cycles with zero-wait memory.

Reset
REQ-030 rst_n=0 asynchronously forces state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, jump_pend=0, pending target=0, misalign=0; hence mem_req=0 and salida_=RESET_PC+4.
REQ-031 Reset during an outstanding request drops it; a late mem_ack after reset shall be ignored per REQ-028.

Configuration
REQ-032 Macro PC_FETCH_ALIGN_CHECK_EN defined: any accepted jump target with bits [1:0] != 0 sets misalign (sticky until reset); the address used has bits [1:0] forced to 0.
REQ-033 Macro PC_FETCH_ALIGN_CHECK_EN undefined: targets are used unmodified and misalign is tied to 0.

Verification
REQ-034 Reset, RESET_PC=0, mem_ack every FETCH cycle, instr_ready=1 -> mem_addr sequence 0,4,8,C; instr equals each mem_rdata in order.
REQ-035 In HOLD with pc=8, sel_direccion=1 and salto=0x100 while instr_ready=1 -> instr_valid drops with no handshake; next mem_addr=0x100.
REQ-036 FETCH at 0x10 with mem_ack delayed 3 cycles, jump to 0x200 in cycle 1 -> mem_addr stays 0x10 until ack; data is discarded; next mem_addr=0x200.
REQ-037 instr_ready=0 for 5 cycles in HOLD -> instr and instr_valid stable; mem_req=0 throughout.
REQ-038 Jump to 0xFFFF_FFFC, then fetch -> next mem_addr=0x0000_0000.
REQ-039 With PC_FETCH_ALIGN_CHECK_EN, jump to 0x102 -> mem_addr=0x100 and misalign=1 until rst_n=0.

Source files
------------

// File: rtl/pc_fetch.sv
// Program-counter fetch stage: IDLE/FETCH/HOLD sequencer issuing one read request at a time, with jump redirect; optional target alignment check via PC_FETCH_ALIGN_CHECK_EN.
// Latency: instr_valid rises one cycle after the mem_ack that returns the word; zero-wait memory gives one instruction per two cycles.
// Backpressure: a held word stays in HOLD until instr_ready or a jump flushes it; an issued memory request is held until mem_ack.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sel_direccion,
  input  logic [31:0] salto,
  output logic [31:0] salida_,
  output logic [31:0] pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        misalign
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_nxt;
  logic [31:0] instr_nxt;
  logic        instr_valid_nxt;
  logic        jump_pend, jump_pend_nxt;
  logic [31:0] pend_tgt, pend_tgt_nxt;
  logic [31:0] tgt_in;

`ifdef PC_FETCH_ALIGN_CHECK_EN
  // Low address bits are dropped; any jump with them set is remembered until reset.
  assign tgt_in = {salto[31:2], 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign <= 1'b0;
    end else if (sel_direccion && (salto[1:0] != 2'b00)) begin
      misalign <= 1'b1;
    end
  end
`else
  assign tgt_in   = salto;
  assign misalign = 1'b0;
`endif

  assign salida_  = pc + 32'd4;
  assign mem_req  = (state == FETCH);
  assign mem_addr = pc;

  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    instr_nxt       = instr;
    instr_valid_nxt = instr_valid;
    jump_pend_nxt   = jump_pend;
    pend_tgt_nxt    = pend_tgt;
    case (state)
      IDLE: begin
        state_nxt = FETCH;
        if (sel_direccion) begin
          pc_nxt = tgt_in;
        end
      end
      FETCH: begin
        if (mem_ack) begin
          if (sel_direccion || jump_pend) begin
            // Wrong-path word: drop it and restart at the newest target.
            pc_nxt        = sel_direccion ? tgt_in : pend_tgt;
            jump_pend_nxt = 1'b0;
          end else begin
            instr_nxt       = mem_rdata;
            instr_valid_nxt = 1'b1;
            pc_nxt          = salida_;
            state_nxt       = HOLD;
          end
        end else if (sel_direccion) begin
          pend_tgt_nxt  = tgt_in;
          jump_pend_nxt = 1'b1;
        end
      end
      HOLD: begin
        if (sel_direccion) begin
          instr_valid_nxt = 1'b0;
          pc_nxt          = tgt_in;
          state_nxt       = FETCH;
        end else if (instr_ready) begin
          instr_valid_nxt = 1'b0;
          state_nxt       = FETCH;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= 32'd0;
      instr_valid <= 1'b0;
      jump_pend   <= 1'b0;
      pend_tgt    <= 32'd0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      instr       <= instr_nxt;
      instr_valid <= instr_valid_nxt;
      jump_pend   <= jump_pend_nxt;
      pend_tgt    <= pend_tgt_nxt;
    end
  end

endmodule
